keyed_miter_sweeper: RTL

- Sequential successor to the combinational org/enc equivalence miter.
- Drives stimulus vectors and a candidate key into an external original/encrypted circuit pair, then compares their OUT_W-bit outputs every cycle.
- Accumulates per-bit equality (Q), the global equal flag (Z), the mismatch count and the first failing vector.
- Used to sweep the input space, exhaustively or pseudo-randomly, when checking a candidate key against a locked netlist.

---
 rtl/miter_pkg.sv | 59 +++++
 rtl/miter_vec_gen.sv | 43 ++++
 rtl/keyed_miter_sweeper.sv | 132 +++++++++++++
 3 files changed

// File: rtl/miter_pkg.sv
// Purpose: shared types and constants for the keyed miter sweeper.
// Latency: n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, vector-generator mode constants and the
// maximal-length Galois LFSR tap table for widths 2..32.
package miter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic MODE_EXH  = 1'b0;
    localparam logic MODE_LFSR = 1'b1;

    // Toggle mask for a right-shifting Galois LFSR: when the bit shifted out
    // is 1, the shifted value is XORed with this mask. Every entry gives a
    // period of 2^width-1, so a nonzero seed never reaches 0.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] taps;
        case (width)
            2:       taps = 32'h0000_0003;
            3:       taps = 32'h0000_0006;
            4:       taps = 32'h0000_000C;
            5:       taps = 32'h0000_0014;
            6:       taps = 32'h0000_0030;
            7:       taps = 32'h0000_0060;
            8:       taps = 32'h0000_00B8;
            9:       taps = 32'h0000_0110;
            10:      taps = 32'h0000_0240;
            11:      taps = 32'h0000_0500;
            12:      taps = 32'h0000_0829;
            13:      taps = 32'h0000_100D;
            14:      taps = 32'h0000_2015;
            15:      taps = 32'h0000_6000;
            16:      taps = 32'h0000_D008;
            17:      taps = 32'h0001_2000;
            18:      taps = 32'h0002_0400;
            19:      taps = 32'h0004_0023;
            20:      taps = 32'h0009_0000;
            21:      taps = 32'h0014_0000;
            22:      taps = 32'h0030_0000;
            23:      taps = 32'h0042_0000;
            24:      taps = 32'h00E1_0000;
            25:      taps = 32'h0120_0000;
            26:      taps = 32'h0200_0023;
            27:      taps = 32'h0400_0013;
            28:      taps = 32'h0900_0000;
            29:      taps = 32'h1400_0000;
            30:      taps = 32'h2000_0029;
            31:      taps = 32'h4800_0000;
            32:      taps = 32'h8020_0003;
            default: taps = 32'h0000_0000;
        endcase
        return taps;
    endfunction

endpackage

// File: rtl/miter_vec_gen.sv
// Purpose: stimulus vector source, binary up-counter or Galois LFSR.
// Latency: load/step take effect at the next rising edge of C.
// Backpressure: none; the vector holds whenever load and step are both low.
// Ports: C/R clock and async active-low reset; load (re)initialises the
// vector to 0 or SEED and latches mode; step advances one position; vec
// is the current vector.
module miter_vec_gen
    import miter_pkg::*;
#(
    parameter int IN_W = 8,
    parameter int SEED = 1
) (
    input  logic            C,
    input  logic            R,
    input  logic            load,
    input  logic            mode,
    input  logic            step,
    output logic [IN_W-1:0] vec
);

    localparam logic [31:0]     TAPS_ALL = lfsr_taps(IN_W);
    localparam logic [IN_W-1:0] TAPS     = TAPS_ALL[IN_W-1:0];
    localparam logic [IN_W-1:0] SEED_V   = IN_W'(SEED);

    logic            mode_q;
    logic [IN_W-1:0] lfsr_next;

    assign lfsr_next = {1'b0, vec[IN_W-1:1]} ^ (vec[0] ? TAPS : '0);

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            vec    <= '0;
            mode_q <= MODE_EXH;
        end else if (load) begin
            mode_q <= mode;
            vec    <= (mode == MODE_LFSR) ? SEED_V : '0;
        end else if (step) begin
            // Counter wraps modulo 2^IN_W naturally.
            vec <= (mode_q == MODE_LFSR) ? lfsr_next : vec + IN_W'(1);
        end
    end

endmodule

// File: rtl/keyed_miter_sweeper.sv
// Purpose: sweep stimulus + key into an org/enc circuit pair and accumulate equality.
// Latency: start accepted at edge 0 -> done_o high in the cycle after edge NUM_VEC.
// Backpressure: none; start_i is ignored outside IDLE and is never queued.
// Ports: C/R clock and async active-low reset; start_i/mode_i/stop_on_fail_i/
// key_i sweep request; vec_o/key_o drive both circuits; org_i/enc_i their
// outputs; busy_o/done_o status; Q_o/Z_o/pass_o/err_cnt_o/first_fail_o results.
module keyed_miter_sweeper
    import miter_pkg::*;
#(
    parameter  int IN_W    = 8,
    parameter  int KEY_W   = 8,
    parameter  int OUT_W   = 2,
    parameter  int NUM_VEC = 256,
    parameter  int SEED    = 1,
    localparam int CNT_W   = $clog2(NUM_VEC + 1)
) (
    input  logic             C,
    input  logic             R,
    input  logic             start_i,
    input  logic             mode_i,
    input  logic             stop_on_fail_i,
    input  logic [KEY_W-1:0] key_i,
    output logic [IN_W-1:0]  vec_o,
    output logic [KEY_W-1:0] key_o,
    input  logic [OUT_W-1:0] org_i,
    input  logic [OUT_W-1:0] enc_i,
    output logic             busy_o,
    output logic             done_o,
    output logic [OUT_W-1:0] Q_o,
    output logic             Z_o,
    output logic             pass_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic [IN_W-1:0]  first_fail_o
);

    localparam logic [CNT_W-1:0] IDX_LAST = CNT_W'(NUM_VEC - 1);

    state_t           state;
    logic             stop_q;
    logic             fail_seen;
    logic [CNT_W-1:0] idx;
    logic [OUT_W-1:0] mism;
    logic             any_mism;
    logic [OUT_W-1:0] q_next;
    logic             accept;
    logic             leave_run;

    // The circuits are combinational from vec_o/key_o, so the compare is
    // always against the vector currently presented.
    assign mism      = org_i ^ enc_i;
    assign any_mism  = |mism;
    assign q_next    = Q_o & ~mism;
    assign accept    = (state == IDLE) && start_i;
    assign leave_run = (idx == IDX_LAST) || (stop_q && any_mism);
    assign Z_o       = &Q_o;

    miter_vec_gen #(
        .IN_W (IN_W),
        .SEED (SEED)
    ) u_vec_gen (
        .C    (C),
        .R    (R),
        .load (accept),
        .mode (mode_i),
        .step (state == RUN),
        .vec  (vec_o)
    );

    always_ff @(posedge C or negedge R) begin
        if (!R) begin
            state        <= IDLE;
            key_o        <= '0;
            stop_q       <= 1'b0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            Q_o          <= '1;
            pass_o       <= 1'b0;
            err_cnt_o    <= '0;
            first_fail_o <= '0;
            fail_seen    <= 1'b0;
            idx          <= '0;
        end else begin
            case (state)
                IDLE: begin
                    done_o <= 1'b0;
                    if (start_i) begin
                        state        <= RUN;
                        busy_o       <= 1'b1;
                        key_o        <= key_i;
                        stop_q       <= stop_on_fail_i;
                        Q_o          <= '1;
                        pass_o       <= 1'b0;
                        err_cnt_o    <= '0;
                        first_fail_o <= '0;
                        fail_seen    <= 1'b0;
                        idx          <= '0;
                    end
                end
                RUN: begin
                    Q_o <= q_next;
                    idx <= idx + CNT_W'(1);
                    if (any_mism) begin
                        err_cnt_o <= err_cnt_o + CNT_W'(1);
                        if (!fail_seen) begin
                            first_fail_o <= vec_o;
                            fail_seen    <= 1'b1;
                        end
                    end
                    if (leave_run) begin
                        state  <= DONE;
                        busy_o <= 1'b0;
                        done_o <= 1'b1;
                        // Post-update Z, registered now so it is already
                        // valid in the same cycle done_o is high.
                        pass_o <= &q_next;
                    end
                end
                DONE: begin
                    state  <= IDLE;
                    done_o <= 1'b0;
                    pass_o <= Z_o;
                end
                default: begin
                    state  <= IDLE;
                    busy_o <= 1'b0;
                    done_o <= 1'b0;
                end
            endcase
        end
    end

endmodule
